i_cache_sa2: RTL
================

Name: i_cache_sa2

Overview:
Second-generation instruction cache with 2-way set associativity, multi-word lines and true-LRU replacement. It sits between the fetch stage and the instruction memory/AXI bridge. Hits complete combinationally in the request cycle. A miss runs a sequential line-refill state machine that fetches the whole line word by word. A global invalidate input supports cache flush.

Parameters:
A_WIDTH, 32, address width in bits
C_INDEX, 6, log2 of number of sets
C_OFFSET, 2, log2 of words per line (LINE_WORDS = 1<<C_OFFSET)

Ports:
clk  in  1  clock, all state on rising edge
clrn  in  1  asynchronous active-low reset
p_a  in  A_WIDTH  fetch byte address, word aligned
p_strobe  in  1  fetch request
p_din  out  32  instruction to CPU
p_ready  out  1  fetch complete this cycle
cache_miss  out  1  request not serviced from cache this cycle
inv_all  in  1  invalidate all lines
m_a  out  A_WIDTH  memory word address
m_strobe  out  1  memory request
m_dout  in  32  memory read data
m_ready  in  1  memory word valid / beat accepted

Behaviour:
- Address split: tag = p_a[A_WIDTH-1 : C_INDEX+C_OFFSET+2]; index = p_a[C_INDEX+C_OFFSET+1 : C_OFFSET+2]; word = p_a[C_OFFSET+1:2].
- T_WIDTH = A_WIDTH-C_INDEX-C_OFFSET-2.
- Per set: valid[2], tag[2], one LRU bit naming the least-recently-used way. Data array holds 2 x sets x LINE_WORDS words.
- FSM states: IDLE, REFILL.
- Reset (clrn=0, async): all valid=0, all LRU=0, state=IDLE, beat counter=0, inv_pending=0.
- Reset outputs: m_strobe=0, p_ready=0, cache_miss=0 while p_strobe=0.
- IDLE:
  - hit = p_strobe & valid[w] & tag[w]==tag for either way.
  - On hit: p_ready=1 and p_din=data[hit way][index][word], same cycle. LRU[index] <= ~hitway.
  - On p_strobe & ~hit: cache_miss=1, p_ready=0. Capture tag/index into miss registers. Select victim: way0 if invalid, else way1 if invalid, else LRU[index]. Go to REFILL with beat counter=0.
- REFILL:
  - m_strobe=1; m_a = {miss_tag, miss_index, cnt, 2'b00}; cache_miss=1; p_ready=0.
  - Each cycle with m_ready=1: write m_dout into data[victim][miss_index][cnt], then cnt++.
  - m_ready=0 stalls the refill with no state change.
  - On the beat where cnt==LINE_WORDS-1 and m_ready=1: write tag[victim]; set valid[victim]=1 unless inv_pending or inv_all is active this cycle; LRU <= ~victim; go to IDLE; clear inv_pending.
- Valid is written only at line completion, so a partially filled line never hits.
- Miss latency: LINE_WORDS accepted beats + 1 cycle. The held request hits in the first IDLE cycle.
- The CPU holds p_a and p_strobe until p_ready. If p_strobe drops mid-refill, the refill still completes (no abort). Refill addressing uses the captured registers only.
- inv_all:
  - In IDLE: clears every valid bit next edge. A hit in that same cycle is still served.
  - In REFILL: clears valid bits and sets inv_pending, so the in-flight line completes but stays invalid.
- Simultaneous inv_all and final beat: invalidate wins.
- Reset asserted mid-refill: immediately return to IDLE with m_strobe=0. Memory-side cleanup is outside this block.
- cnt wraps only via the completion transition and is never incremented past LINE_WORDS-1.

Test Plan:
- Cold miss, defaults (C_OFFSET=2), p_a=0x00001008, m_ready always 1 -> m_a sequence 0x1000, 0x1004, 0x1008, 0x100C on 4 consecutive cycles; p_ready on cycle 5 with p_din = word written at 0x1008. A following fetch of 0x100C hits in 1 cycle with m_strobe=0.
- Two tags, same set: 0x00001000 then 0x00002000 (index 0) -> both refilled into way0 and way1. Refetching both hits. Then 0x00001000 hit followed by 0x00003000 miss -> evicts 0x2000's way; 0x1000 still hits, 0x2000 misses.
- Stalled memory: m_ready pattern 1,0,0,1,0,1,1 -> m_a advances only on m_ready beats, exactly 4 data writes, p_ready exactly once, after the last beat.
- inv_all in IDLE after filling 3 lines -> every subsequent fetch of those addresses misses and re-refills.
- inv_all on beat 2 of a refill -> refill completes (4 beats), next cycle still misses and a second refill of the same line starts.
- clrn pulsed low during beat 1 of a refill -> m_strobe=0 and p_ready=0 immediately. After release, a fetch of the same address is a miss.

Source files
------------

// File: rtl/i_cache_sa2_if.sv
// Fetch-side and memory-side handshake bundle for the 2-way instruction cache.
// The cache takes the slave view; the fetch/memory environment takes the master view.
interface i_cache_sa2_if #(
   parameter int A_WIDTH = 32
);
   logic [A_WIDTH-1:0] p_a;
   logic               p_strobe;
   logic [31:0]        p_din;
   logic               p_ready;
   logic               cache_miss;
   logic [A_WIDTH-1:0] m_a;
   logic               m_strobe;
   logic [31:0]        m_dout;
   logic               m_ready;

   modport slave (
      input  p_a, p_strobe, m_dout, m_ready,
      output p_din, p_ready, cache_miss, m_a, m_strobe
   );

   modport master (
      output p_a, p_strobe, m_dout, m_ready,
      input  p_din, p_ready, cache_miss, m_a, m_strobe
   );
endinterface

// File: rtl/i_cache_sa2.sv
// 2-way set-associative instruction cache with true-LRU and multi-word line refill.
// Hits are served combinationally; a miss fetches the whole line beat by beat.
module i_cache_sa2 #(
   parameter int A_WIDTH  = 32,
   parameter int C_INDEX  = 6,
   parameter int C_OFFSET = 2
) (
   input logic          clk,
   input logic          clrn,
   input logic          inv_all,
   i_cache_sa2_if.slave bus
);
   localparam int SETS    = 1 << C_INDEX;
   localparam int LW      = 1 << C_OFFSET;
   localparam int T_WIDTH = A_WIDTH - C_INDEX - C_OFFSET - 2;

   typedef enum logic {IDLE, REFILL} state_t;

   state_t               state, state_nx;
   logic [T_WIDTH-1:0]   tag_in, miss_tag;
   logic [C_INDEX-1:0]   idx, miss_idx;
   logic [C_OFFSET-1:0]  word, cnt;
   logic [SETS-1:0]      valid0, valid1, lru;
   logic [T_WIDTH-1:0]   tag0 [SETS];
   logic [T_WIDTH-1:0]   tag1 [SETS];
   logic [31:0]          data_mem [2][SETS][LW];
   logic                 victim, inv_pending;
   logic                 hit0, hit1, hit, last_beat;
   logic [1:0]           unused_bits;

   assign tag_in      = bus.p_a[A_WIDTH-1 -: T_WIDTH];
   assign idx         = bus.p_a[C_OFFSET+2 +: C_INDEX];
   assign word        = bus.p_a[2 +: C_OFFSET];
   assign unused_bits = bus.p_a[1:0];

   assign hit0      = valid0[idx] && (tag0[idx] == tag_in);
   assign hit1      = valid1[idx] && (tag1[idx] == tag_in);
   assign hit       = (state == IDLE) && bus.p_strobe && (hit0 || hit1);
   assign last_beat = (state == REFILL) && bus.m_ready && (cnt == C_OFFSET'(LW - 1));

   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) state <= IDLE;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx       = state;
      bus.p_ready    = 1'b0;
      bus.p_din      = '0;
      bus.cache_miss = 1'b0;
      bus.m_strobe   = 1'b0;
      bus.m_a        = '0;
      case (state)
         IDLE: begin
            if (hit) begin
               bus.p_ready = 1'b1;
               bus.p_din   = hit0 ? data_mem[0][idx][word] : data_mem[1][idx][word];
            end else if (bus.p_strobe) begin
               bus.cache_miss = 1'b1;
               state_nx       = REFILL;
            end
         end
         REFILL: begin
            bus.m_strobe   = 1'b1;
            bus.m_a        = {miss_tag, miss_idx, cnt, 2'b00};
            bus.cache_miss = 1'b1;
            if (last_beat) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   // Bulk invalidate clears first; a completing fill may then set only its own way.
   always_ff @(posedge clk or negedge clrn) begin
      if (!clrn) begin
         valid0      <= '0;
         valid1      <= '0;
         lru         <= '0;
         cnt         <= '0;
         inv_pending <= 1'b0;
         victim      <= 1'b0;
         miss_tag    <= '0;
         miss_idx    <= '0;
      end else begin
         if (inv_all) begin
            valid0 <= '0;
            valid1 <= '0;
         end
         if (state == IDLE) begin
            if (hit) begin
               lru[idx] <= hit0;
            end else if (bus.p_strobe) begin
               miss_tag    <= tag_in;
               miss_idx    <= idx;
               cnt         <= '0;
               inv_pending <= 1'b0;
               victim      <= !valid0[idx] ? 1'b0 : (!valid1[idx] ? 1'b1 : lru[idx]);
            end
         end else begin
            if (inv_all) inv_pending <= 1'b1;
            if (bus.m_ready) cnt <= cnt + 1'b1;
            if (last_beat) begin
               if (!(inv_pending || inv_all)) begin
                  if (victim) valid1[miss_idx] <= 1'b1;
                  else        valid0[miss_idx] <= 1'b1;
               end
               lru[miss_idx] <= ~victim;
               inv_pending   <= 1'b0;
            end
         end
      end
   end

   // Tag and data arrays need no reset: valid bits gate every lookup.
   always_ff @(posedge clk) begin
      if (state == REFILL && bus.m_ready) begin
         data_mem[victim][miss_idx][cnt] <= bus.m_dout;
      end
      if (last_beat) begin
         if (victim) tag1[miss_idx] <= miss_tag;
         else        tag0[miss_idx] <= miss_tag;
      end
   end
endmodule
